// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: states, opcodes,
// ALU / PC-source / write-back encodings and the control-word payload.
package multicycle_ctrl_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ST_W     = 3;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned ALUCTL_W = 4;
  localparam int unsigned PCSRC_W  = 2;
  localparam int unsigned WBSEL_W  = 2;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLT = 3'b010;
  localparam logic [F3_W-1:0] F3_OR  = 3'b110;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_REL = 2'b01;

  localparam logic [WBSEL_W-1:0] WBSEL_ALU  = 2'b00;
  localparam logic [WBSEL_W-1:0] WBSEL_LOAD = 2'b01;
  localparam logic [WBSEL_W-1:0] WBSEL_LINK = 2'b10;

  // Per-cycle control word driven toward memories and datapath.
  typedef struct packed {
    logic                imem_req;
    logic                dmem_req;
    logic                dmem_we;
    logic                ir_write;
    logic                pc_write;
    logic [PCSRC_W-1:0]  pc_src;
    logic [ALUCTL_W-1:0] alu_ctl;
    logic                alu_src;
    logic                reg_write;
    logic [WBSEL_W-1:0]  wb_sel;
    logic                illegal;
    logic                retire;
  } ctrl_t;

  function automatic logic opcode_supported(input logic [OPC_W-1:0] opc);
    return (opc == OP_R) || (opc == OP_IMM) || (opc == OP_LOAD) ||
           (opc == OP_STORE) || (opc == OP_BRANCH) || (opc == OP_JAL);
  endfunction

  // BEQ takes on zero, BNE (funct3[0]=1) takes on non-zero.
  function automatic logic branch_taken(input logic zero, input logic is_bne);
    return zero ^ is_bne;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]    opcode_i,
  input  logic [F3_W-1:0]     funct3_i,
  input  logic                funct7b5_i,
  output logic [ALUCTL_W-1:0] alu_ctl_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    case (opcode_i)
      OP_R, OP_IMM: begin
        case (funct3_i)
          // Only register-register ADD/SUB uses funct7[5]; ADDI's bit 30 is immediate.
          F3_ADD:  alu_ctl_o = (opcode_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          F3_SLT:  alu_ctl_o = ALU_SLT;
          F3_OR:   alu_ctl_o = ALU_OR;
          F3_AND:  alu_ctl_o = ALU_AND;
          default: alu_ctl_o = ALU_ADD;
        endcase
      end
      OP_BRANCH: alu_ctl_o = ALU_SUB;
      default:   alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath.
// Control outputs are decoded each cycle from the state register, IR fields and acks.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned STATE_W = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [XLEN-1:0]    i_Instr,
  input  logic               i_Zero,
  output logic               o_IMemReq,
  input  logic               i_IMemAck,
  output logic               o_DMemReq,
  output logic               o_DMemWe,
  input  logic               i_DMemAck,
  output logic               o_IRWrite,
  output logic               o_PCWrite,
  output logic [1:0]         o_PCSrc,
  output logic [3:0]         o_ALUctl,
  output logic               o_ALUsrc,
  output logic               o_RegWrite,
  output logic [1:0]         o_WBSel,
  output logic               o_Illegal,
  output logic               o_Retire,
  output logic [STATE_W-1:0] o_State
);

  state_e               state_q, state_d;
  ctrl_t                ctrl_c;
  logic [OPC_W-1:0]     opcode;
  logic [F3_W-1:0]      funct3;
  logic                 funct7b5;
  logic [ALUCTL_W-1:0]  alu_ctl_c;
  logic                 unused_instr_bits;

  assign opcode   = i_Instr[6:0];
  assign funct3   = i_Instr[14:12];
  assign funct7b5 = i_Instr[30];

  // Register, immediate and rd fields belong to the datapath, not the sequencer.
  assign unused_instr_bits = ^{i_Instr[XLEN-1], i_Instr[29:15], i_Instr[11:7]};

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .alu_ctl_o  (alu_ctl_c)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle control word.
  always_comb begin
    state_d = ST_FETCH;
    ctrl_c  = '0;

    case (state_q)
      ST_FETCH: begin
        ctrl_c.imem_req = 1'b1;
        if (i_IMemAck) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PCSRC_SEQ;
          state_d         = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        if (opcode_supported(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          ctrl_c.illegal = 1'b1;
          state_d        = ST_FETCH;
        end
      end

      ST_EXEC: begin
        ctrl_c.alu_ctl = alu_ctl_c;
        case (opcode)
          OP_R: begin
            ctrl_c.alu_src = 1'b0;
            state_d        = ST_WB;
          end
          OP_IMM: begin
            ctrl_c.alu_src = 1'b1;
            state_d        = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_c.alu_src = 1'b1;
            state_d        = ST_MEM;
          end
          OP_BRANCH: begin
            ctrl_c.alu_src = 1'b0;
            ctrl_c.retire  = 1'b1;
            if (branch_taken(i_Zero, funct3[0])) begin
              ctrl_c.pc_write = 1'b1;
              ctrl_c.pc_src   = PCSRC_REL;
            end
            state_d = ST_FETCH;
          end
          OP_JAL: begin
            ctrl_c.pc_write  = 1'b1;
            ctrl_c.pc_src    = PCSRC_REL;
            ctrl_c.reg_write = 1'b1;
            ctrl_c.wb_sel    = WBSEL_LINK;
            ctrl_c.retire    = 1'b1;
            state_d          = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        ctrl_c.dmem_req = 1'b1;
        ctrl_c.dmem_we  = (opcode == OP_STORE);
        if (i_DMemAck) begin
          if (opcode == OP_STORE) begin
            ctrl_c.retire = 1'b1;
            state_d       = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.wb_sel    = (opcode == OP_LOAD) ? WBSEL_LOAD : WBSEL_ALU;
        ctrl_c.retire    = 1'b1;
        state_d          = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset silences everything, including a pending fetch and any same-cycle ack.
    if (i_Rst) begin
      ctrl_c = '0;
    end
  end

  assign o_IMemReq  = ctrl_c.imem_req;
  assign o_DMemReq  = ctrl_c.dmem_req;
  assign o_DMemWe   = ctrl_c.dmem_we;
  assign o_IRWrite  = ctrl_c.ir_write;
  assign o_PCWrite  = ctrl_c.pc_write;
  assign o_PCSrc    = ctrl_c.pc_src;
  assign o_ALUctl   = ctrl_c.alu_ctl;
  assign o_ALUsrc   = ctrl_c.alu_src;
  assign o_RegWrite = ctrl_c.reg_write;
  assign o_WBSel    = ctrl_c.wb_sel;
  assign o_Illegal  = ctrl_c.illegal;
  assign o_Retire   = ctrl_c.retire;
  assign o_State    = i_Rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: memory responders feed queued instructions,
// a monitor summarises each completed instruction and checks it against a reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic [3:0]  alu_ctl;
  logic        alu_src, reg_write;
  logic [1:0]  wb_sel;
  logic        illegal, retire;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Instr    (instr),
    .i_Zero     (zero),
    .o_IMemReq  (imem_req),
    .i_IMemAck  (imem_ack),
    .o_DMemReq  (dmem_req),
    .o_DMemWe   (dmem_we),
    .i_DMemAck  (dmem_ack),
    .o_IRWrite  (ir_write),
    .o_PCWrite  (pc_write),
    .o_PCSrc    (pc_src),
    .o_ALUctl   (alu_ctl),
    .o_ALUsrc   (alu_src),
    .o_RegWrite (reg_write),
    .o_WBSel    (wb_sel),
    .o_Illegal  (illegal),
    .o_Retire   (retire),
    .o_State    (state)
  );

  typedef struct {
    logic [31:0] instr;
    int          iw;
    int          dw;
    bit          z;
  } stim_t;

  // Observable summary of one instruction, from first fetch cycle to retire/illegal.
  typedef struct {
    bit          illegal;
    int          cycles;
    int          n_irw;
    int          n_pcw;
    logic [1:0]  pcsrc;
    int          n_rw;
    logic [1:0]  wbsel;
    int          dcyc;
    bit          we;
    int          we_noreq;
    bit          chk_alu;
    logic [3:0]  alu;
    bit          alusrc;
  } rec_t;

  stim_t stim_q[$];
  rec_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  int    dwait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [6:0] opc, input logic [2:0] f3, input bit f7b);
    if (opc == 7'h63) return 4'b0110;
    if (opc == 7'h03 || opc == 7'h23) return 4'b0010;
    case (f3)
      3'd0:    return (opc == 7'h33 && f7b) ? 4'b0110 : 4'b0010;
      3'd2:    return 4'b0111;
      3'd6:    return 4'b0001;
      3'd7:    return 4'b0000;
      default: return 4'b0010;
    endcase
  endfunction

  // Reference: latency is fetch (1+iw) + decode + the stages each class visits.
  function automatic rec_t model(input stim_t s);
    rec_t       r;
    logic [6:0] opc;
    logic [2:0] f3;
    bit         taken;
    r = '{default: 0};
    opc = s.instr[6:0];
    f3  = s.instr[14:12];
    r.n_irw = 1;
    r.n_pcw = 1;
    r.pcsrc = 2'b00;
    case (opc)
      7'h33, 7'h13: begin
        r.cycles  = s.iw + 4;
        r.n_rw    = 1;
        r.wbsel   = 2'b00;
        r.chk_alu = 1;
        r.alu     = alu_ref(opc, f3, s.instr[30]);
        r.alusrc  = (opc == 7'h13);
      end
      7'h03: begin
        r.cycles = s.iw + s.dw + 5;
        r.n_rw = 1; r.wbsel = 2'b01; r.dcyc = s.dw + 1;
        r.chk_alu = 1; r.alu = 4'b0010; r.alusrc = 1;
      end
      7'h23: begin
        r.cycles = s.iw + s.dw + 4;
        r.dcyc = s.dw + 1; r.we = 1;
        r.chk_alu = 1; r.alu = 4'b0010; r.alusrc = 1;
      end
      7'h63: begin
        taken = s.z ^ f3[0];
        r.cycles = s.iw + 3;
        r.n_pcw = taken ? 2 : 1;
        r.pcsrc = taken ? 2'b01 : 2'b00;
        r.chk_alu = 1; r.alu = 4'b0110; r.alusrc = 0;
      end
      7'h6F: begin
        r.cycles = s.iw + 3;
        r.n_pcw = 2; r.pcsrc = 2'b01;
        r.n_rw = 1; r.wbsel = 2'b10;
      end
      default: begin
        r.illegal = 1;
        r.cycles  = s.iw + 2;
      end
    endcase
    return r;
  endfunction

  function automatic stim_t gen();
    stim_t      s;
    logic [31:0] w;
    logic [2:0] f3;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       f3 = 3'd0;
      1:       f3 = 3'd2;
      2:       f3 = 3'd6;
      default: f3 = 3'd7;
    endcase
    case ($urandom_range(0, 6))
      0: begin
        w[6:0] = 7'h33; w[14:12] = f3;
        w[31:25] = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: begin w[6:0] = 7'h13; w[14:12] = f3; end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
      3: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
      4: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
      5: w[6:0] = 7'h6F;
      default: begin
        case ($urandom_range(0, 3))
          0:       w[6:0] = 7'h7F;
          1:       w[6:0] = 7'h37;
          2:       w[6:0] = 7'h17;
          default: w[6:0] = 7'h73;
        endcase
      end
    endcase
    s.instr = w;
    s.iw    = int'($urandom_range(0, 3));
    s.dw    = int'($urandom_range(0, 3));
    s.z     = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic issue(input logic [31:0] w, input int iw, input int dw, input bit z);
    stim_t s;
    s = '{instr: w, iw: iw, dw: dw, z: z};
    stim_q.push_back(s);
    exp_q.push_back(model(s));
  endtask

  // Instruction memory: acks the head of the stimulus queue after iw wait cycles.
  initial begin
    int    icnt;
    stim_t s;
    icnt = 0;
    imem_ack = 1'b0;
    instr = 32'h0;
    zero = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (imem_req && stim_q.size() > 0) begin
        if (icnt == stim_q[0].iw) begin
          s = stim_q.pop_front();
          imem_ack = 1'b1;
          instr = s.instr;
          zero = s.z;
          dwait = s.dw;
          icnt = 0;
        end else begin
          imem_ack = 1'b0;
          icnt++;
        end
      end else begin
        imem_ack = imem_req ? 1'b0 : 1'($urandom_range(0, 1));
        icnt = 0;
      end
    end
  end

  // Data memory: acks after dwait cycles; stray acks with no request must be ignored.
  initial begin
    int dcnt;
    dcnt = 0;
    dmem_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (dmem_req) begin
        if (dcnt == dwait) begin
          dmem_ack = 1'b1;
          dcnt = 0;
        end else begin
          dmem_ack = 1'b0;
          dcnt++;
        end
      end else begin
        dmem_ack = 1'($urandom_range(0, 3) == 0);
        dcnt = 0;
      end
    end
  end

  // Monitor: accumulate one instruction, compare against the scoreboard at its last cycle.
  initial begin
    rec_t o;
    rec_t e;
    o = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        o = '{default: 0};
      end else begin
        o.cycles++;
        if (ir_write) o.n_irw++;
        if (pc_write) begin o.n_pcw++; o.pcsrc = pc_src; end
        if (reg_write) begin o.n_rw++; o.wbsel = wb_sel; end
        if (dmem_req) begin o.dcyc++; if (dmem_we) o.we = 1; end
        if (dmem_we && !dmem_req) o.we_noreq++;
        if (state == 3'd2) begin o.alu = alu_ctl; o.alusrc = alu_src; end
        if (illegal) o.illegal = 1;
        if (retire || illegal) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("illegal",   32'(o.illegal),  32'(e.illegal));
            chk("latency",   32'(o.cycles),   32'(e.cycles));
            chk("ir_writes", 32'(o.n_irw),    32'(e.n_irw));
            chk("pc_writes", 32'(o.n_pcw),    32'(e.n_pcw));
            chk("pc_src",    32'(o.pcsrc),    32'(e.pcsrc));
            chk("reg_writes",32'(o.n_rw),     32'(e.n_rw));
            chk("wb_sel",    32'(o.wbsel),    32'(e.wbsel));
            chk("dmem_cyc",  32'(o.dcyc),     32'(e.dcyc));
            chk("dmem_we",   32'(o.we),       32'(e.we));
            chk("we_noreq",  32'(o.we_noreq), 32'd0);
            if (e.chk_alu) begin
              chk("alu_ctl", 32'(o.alu),    32'(e.alu));
              chk("alu_src", 32'(o.alusrc), 32'(e.alusrc));
            end
          end
          o = '{default: 0};
        end
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(32'h001101B3, 0, 0, 1'b0);   // add x3,x2,x1
    issue(32'h0000A203, 0, 3, 1'b0);   // lw x4,0(x1), data ack after 3 waits
    issue(32'h00208063, 0, 0, 1'b1);   // beq, zero=1 -> taken
    issue(32'h00209063, 0, 0, 1'b1);   // bne, zero=1 -> not taken
    issue(32'h0000007F, 0, 0, 1'b0);   // unsupported opcode
    issue(32'h0020A023, 1, 2, 1'b0);   // sw with waits on both memories
    for (int i = 0; i < 60; i++) begin
      stim_t s;
      s = gen();
      issue(s.instr, s.iw, s.dw, s.z);
    end

    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 32'({imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_ctl,
                                alu_src, reg_write, wb_sel, illegal, retire, state}), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("imem_req_after_reset", 32'(imem_req), 32'd1);

    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset abandons a store mid-MEM even with the data ack in the same cycle.
    mon_en = 1'b0;
    stim_q.push_back('{instr: 32'h0020A023, iw: 0, dw: 1000, z: 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dmem_req) seen = 1'b1;
    end
    chk("abort_reached_mem", 32'(seen), 32'd1);
    chk("abort_store_we", 32'(dmem_we), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #2 dmem_ack = 1'b1;
    @(negedge clk);
    chk("abort_retire", 32'(retire), 32'd0);
    chk("abort_regwrite", 32'(reg_write), 32'd0);
    chk("abort_dmem_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state_fetch", 32'(state), 32'd0);
    chk("abort_imem_req", 32'(imem_req), 32'd1);
    chk("abort_dmem_req_after", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("abort_no_retire_after", 32'(retire), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
